// File: rtl/ntsc_cvbs_enc.sv
// ntsc_cvbs_enc
// Composite-video (CVBS) encoder for the 4fsc NTSC pipeline. It takes the
// timing generator's SYNC/BLANK/BURST strobes and Y/U/V pixel data and
// produces one 10-bit DAC code per 4fsc sample: sync tip, blanking, colour
// burst, or active video with quadrature-modulated chroma. At 4fsc the
// subcarrier is a 4-phase sequence, so a 2-bit counter replaces an NCO.
//
// Ports:
//   CK_i      4fsc clock
//   AR_i      asynchronous active-high reset
//   XR_i      synchronous active-low phase clear, qualified by CK_EE_i
//   CK_EE_i   clock enable; all state advances only when it is 1
//   SYNC_i    0 = sync tip
//   BLANK_i   1 = blanking
//   BURST_i   1 = colour burst window
//   Y_i       luma, unsigned 0..255
//   U_i       B-Y, signed two's complement
//   V_i       R-Y, signed two's complement
//   DAC_o     composite code, unsigned, saturated 0..1023
//   Q_SYNC_o  SYNC_i delayed to line up with DAC_o
//   Q_PH_o    subcarrier phase of the sample currently on DAC_o
//
// Latency is three enabled cycles from the inputs to DAC_o.

module ntsc_cvbs_enc #(
  parameter logic [9:0] C_SYNC_LEVEL  = 10'd16,
  parameter logic [9:0] C_BLANK_LEVEL = 10'd240,
  parameter logic [9:0] C_BLACK_LEVEL = 10'd282,
  parameter logic [9:0] C_BURST_AMP   = 10'd112
) (
  input  logic       CK_i,
  input  logic       AR_i,
  input  logic       XR_i,
  input  logic       CK_EE_i,
  input  logic       SYNC_i,
  input  logic       BLANK_i,
  input  logic       BURST_i,
  input  logic [7:0] Y_i,
  input  logic [7:0] U_i,
  input  logic [7:0] V_i,
  output logic [9:0] DAC_o,
  output logic       Q_SYNC_o,
  output logic [1:0] Q_PH_o
);

  // Subcarrier phase counter
  logic [1:0] r_ph;

  // Stage 1: registered inputs and the phase they were sampled with
  logic       r_s1Sync;
  logic       r_s1Blank;
  logic       r_s1Burst;
  logic [7:0] r_s1Y;
  logic [7:0] r_s1U;
  logic [7:0] r_s1V;
  logic [1:0] r_s1Ph;

  // Stage 2: strobes plus luma and chroma terms
  logic              r_s2Sync;
  logic              r_s2Blank;
  logic              r_s2Burst;
  logic [9:0]        r_s2Luma;
  logic signed [11:0] r_s2Chroma;
  logic [1:0]        r_s2Ph;

  // Stage 3: output registers
  logic [9:0] r_dac;
  logic       r_qSync;
  logic [1:0] r_qPh;

  // Combinational terms
  logic signed [11:0] w_uX2;
  logic signed [11:0] w_vX2;
  logic signed [11:0] w_burstAmp;
  logic signed [11:0] w_chroma;
  logic [9:0]         w_luma;
  logic signed [11:0] w_base;
  logic signed [11:0] w_sum;
  logic [9:0]         w_sat;
  logic [9:0]         w_dacNext;

  // The phase counter is free-running. 910 samples per line is 2 mod 4, so
  // the burst and chroma phases invert from line to line without extra
  // logic. XR_i realigns the counter but leaves the data pipeline alone.
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      r_ph <= 2'd0;
    end else if (CK_EE_i) begin
      if (!XR_i) r_ph <= 2'd0;
      else       r_ph <= r_ph + 2'd1;
    end
  end

  // Stage 1 captures the inputs together with the current phase.
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      r_s1Sync  <= 1'b1;
      r_s1Blank <= 1'b1;
      r_s1Burst <= 1'b0;
      r_s1Y     <= 8'd0;
      r_s1U     <= 8'd0;
      r_s1V     <= 8'd0;
      r_s1Ph    <= 2'd0;
    end else if (CK_EE_i) begin
      r_s1Sync  <= SYNC_i;
      r_s1Blank <= BLANK_i;
      r_s1Burst <= BURST_i;
      r_s1Y     <= Y_i;
      r_s1U     <= U_i;
      r_s1V     <= V_i;
      r_s1Ph    <= r_ph;
    end
  end

  // The U and V inputs are sign-extended to 12 bits and doubled. With 12
  // bits, negating -256 gives +256 without overflow.
  assign w_uX2      = {{3{r_s1U[7]}}, r_s1U, 1'b0};
  assign w_vX2      = {{3{r_s1V[7]}}, r_s1V, 1'b0};
  assign w_burstAmp = {2'b00, C_BURST_AMP};
  assign w_luma     = C_BLACK_LEVEL + {1'b0, r_s1Y, 1'b0};

  // The chroma term comes from the phase. The burst sits on the -U axis.
  // Active video rotates +U, +V, -U, -V.
  always_comb begin
    w_chroma = 12'sd0;
    if (r_s1Burst) begin
      case (r_s1Ph)
        2'd0:    w_chroma = -w_burstAmp;
        2'd2:    w_chroma = w_burstAmp;
        default: w_chroma = 12'sd0;
      endcase
    end else begin
      case (r_s1Ph)
        2'd0:    w_chroma = w_uX2;
        2'd1:    w_chroma = w_vX2;
        2'd2:    w_chroma = -w_uX2;
        default: w_chroma = -w_vX2;
      endcase
    end
  end

  // Stage 2 holds the luma and chroma terms alongside the delayed strobes.
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      r_s2Sync   <= 1'b1;
      r_s2Blank  <= 1'b1;
      r_s2Burst  <= 1'b0;
      r_s2Luma   <= 10'd0;
      r_s2Chroma <= 12'sd0;
      r_s2Ph     <= 2'd0;
    end else if (CK_EE_i) begin
      r_s2Sync   <= r_s1Sync;
      r_s2Blank  <= r_s1Blank;
      r_s2Burst  <= r_s1Burst;
      r_s2Luma   <= w_luma;
      r_s2Chroma <= w_chroma;
      r_s2Ph     <= r_s1Ph;
    end
  end

  // The burst rides on blanking level and active video on the luma term.
  // The 12-bit sum can only exceed 1023 from below 2048, so bit 10 flags
  // the overflow and bit 11 flags a negative result.
  assign w_base = r_s2Burst ? {2'b00, C_BLANK_LEVEL} : {2'b00, r_s2Luma};
  assign w_sum  = w_base + r_s2Chroma;

  always_comb begin
    w_sat = w_sum[9:0];
    if (w_sum[11])      w_sat = 10'd0;
    else if (w_sum[10]) w_sat = 10'd1023;
  end

  // Output priority: sync, then burst (whether or not BLANK is set), then
  // blanking, then active video.
  always_comb begin
    w_dacNext = w_sat;
    if (!r_s2Sync)     w_dacNext = C_SYNC_LEVEL;
    else if (r_s2Burst) w_dacNext = w_sat;
    else if (r_s2Blank) w_dacNext = C_BLANK_LEVEL;
  end

  // Stage 3 registers the DAC code and its tracking outputs.
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      r_dac   <= C_BLANK_LEVEL;
      r_qSync <= 1'b1;
      r_qPh   <= 2'd0;
    end else if (CK_EE_i) begin
      r_dac   <= w_dacNext;
      r_qSync <= r_s2Sync;
      r_qPh   <= r_s2Ph;
    end
  end

  assign DAC_o    = r_dac;
  assign Q_SYNC_o = r_qSync;
  assign Q_PH_o   = r_qPh;

endmodule

// File: tb/tb_ntsc_cvbs_enc.sv
// tb_ntsc_cvbs_enc
// Directed testbench for ntsc_cvbs_enc. Inputs change 1 ns after a rising
// edge. Outputs are sampled at that same point, so a sample driven after
// edge n appears on DAC_o after edge n+3.

module tb_ntsc_cvbs_enc;

  logic       CK_i = 1'b0;
  logic       AR_i;
  logic       XR_i;
  logic       CK_EE_i;
  logic       SYNC_i;
  logic       BLANK_i;
  logic       BURST_i;
  logic [7:0] Y_i;
  logic [7:0] U_i;
  logic [7:0] V_i;
  logic [9:0] DAC_o;
  logic       Q_SYNC_o;
  logic [1:0] Q_PH_o;

  int totalChecks = 0;
  int badChecks   = 0;

  int burstTbl  [4] = '{128, 240, 352, 240};
  int chromaTbl [4] = '{522, 422, 442, 542};
  int xrDac     [5] = '{522, 422, 442, 522, 422};
  int xrPh      [5] = '{0, 1, 2, 0, 1};

  ntsc_cvbs_enc dut (
    .CK_i     (CK_i),
    .AR_i     (AR_i),
    .XR_i     (XR_i),
    .CK_EE_i  (CK_EE_i),
    .SYNC_i   (SYNC_i),
    .BLANK_i  (BLANK_i),
    .BURST_i  (BURST_i),
    .Y_i      (Y_i),
    .U_i      (U_i),
    .V_i      (V_i),
    .DAC_o    (DAC_o),
    .Q_SYNC_o (Q_SYNC_o),
    .Q_PH_o   (Q_PH_o)
  );

  // 4fsc clock, 10 ns period
  always #5 CK_i = ~CK_i;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick;
    @(posedge CK_i);
    #1;
  endtask

  // Drive one input vector. U and V are given as signed integers.
  task automatic applyStimulus(input logic s, input logic b, input logic bu,
                               input int y, input int u, input int v);
    SYNC_i  = s;
    BLANK_i = b;
    BURST_i = bu;
    Y_i     = 8'(y);
    U_i     = 8'(u);
    V_i     = 8'(v);
  endtask

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    totalChecks++;
    if (actual != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Pulse XR_i for one enabled cycle. The next sample is then taken at phase 0.
  task automatic clearPhase;
    XR_i = 1'b0;
    tick();
    XR_i = 1'b1;
  endtask

  // Hold a vector until the sample taken at phase ph reaches the output.
  task automatic runVec(input string tag, input logic s, input logic b, input logic bu,
                        input int y, input int u, input int v, input int ph, input int expected);
    clearPhase();
    applyStimulus(s, b, bu, y, u, v);
    repeat (3 + ph) tick();
    checkOutput(tag, int'(DAC_o), expected);
    checkOutput({tag, "_ph"}, int'(Q_PH_o), ph);
  endtask

  initial begin
    AR_i    = 1'b1;
    XR_i    = 1'b1;
    CK_EE_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 200, -50, 77);

    // Reset state with arbitrary inputs applied
    repeat (3) tick();
    checkOutput("rst_dac", int'(DAC_o), 240);
    checkOutput("rst_qsync", int'(Q_SYNC_o), 1);
    checkOutput("rst_qph", int'(Q_PH_o), 0);

    // Sync first reaches the output on the third enabled edge
    AR_i = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    tick();
    checkOutput("sync_lat1", int'(DAC_o), 240);
    tick();
    checkOutput("sync_lat2", int'(DAC_o), 240);
    checkOutput("sync_lat2_q", int'(Q_SYNC_o), 1);
    tick();
    checkOutput("sync_lat3", int'(DAC_o), 16);
    checkOutput("sync_lat3_q", int'(Q_SYNC_o), 0);

    // Burst sequence from phase 0
    clearPhase();
    applyStimulus(1'b1, 1'b1, 1'b1, 0, 0, 0);
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t >= 3) begin
        checkOutput($sformatf("burst_%0d", t - 3), int'(DAC_o), burstTbl[(t - 3) % 4]);
        checkOutput($sformatf("burst_ph_%0d", t - 3), int'(Q_PH_o), (t - 3) % 4);
      end
    end

    // Active chroma with Y=100, U=+20, V=-30
    clearPhase();
    applyStimulus(1'b1, 1'b0, 1'b0, 100, 20, -30);
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t >= 3)
        checkOutput($sformatf("chroma_%0d", t - 3), int'(DAC_o), chromaTbl[(t - 3) % 4]);
    end

    // Saturation, negation range and output priority
    runVec("sat_hi",      1'b1, 1'b0, 1'b0, 255,  127,   0, 0, 1023);
    runVec("sat_u_ph2",   1'b1, 1'b0, 1'b0,   0,  127,   0, 2,   28);
    runVec("neg_m128",    1'b1, 1'b0, 1'b0,   0, -128,   0, 2,  538);
    runVec("sat_v_ph3",   1'b1, 1'b0, 1'b0,   0,    0, 127, 3,   28);
    runVec("burst_noblk", 1'b1, 1'b0, 1'b1,  90,   40,  40, 2,  352);
    runVec("sync_prio",   1'b0, 1'b1, 1'b1,  90,   40,  40, 0,   16);
    runVec("blank_only",  1'b1, 1'b1, 1'b0, 255,  127, 127, 1,  240);

    // Clock enable: disabled cycles hold the output, and latency counts
    // only enabled cycles.
    clearPhase();
    applyStimulus(1'b1, 1'b0, 1'b0, 100, 20, -30);
    for (int t = 1; t <= 6; t++) begin
      CK_EE_i = 1'b1;
      tick();
      if (t >= 3)
        checkOutput($sformatf("ee_on_%0d", t), int'(DAC_o), chromaTbl[(t - 3) % 4]);
      CK_EE_i = 1'b0;
      tick();
      tick();
      if (t >= 3) begin
        checkOutput($sformatf("ee_hold_%0d", t), int'(DAC_o), chromaTbl[(t - 3) % 4]);
        checkOutput($sformatf("ee_hold_ph_%0d", t), int'(Q_PH_o), (t - 3) % 4);
      end
    end
    CK_EE_i = 1'b1;

    // XR_i low for one enabled cycle while the sample at phase 2 is taken
    clearPhase();
    applyStimulus(1'b1, 1'b0, 1'b0, 100, 20, -30);
    for (int t = 1; t <= 7; t++) begin
      XR_i = (t == 3) ? 1'b0 : 1'b1;
      tick();
      if (t >= 3) begin
        checkOutput($sformatf("xr_dac_%0d", t), int'(DAC_o), xrDac[t - 3]);
        checkOutput($sformatf("xr_ph_%0d", t), int'(Q_PH_o), xrPh[t - 3]);
      end
    end
    XR_i = 1'b1;

    // Three 910-sample lines. The burst phase alternates from line to line.
    clearPhase();
    for (int ln = 0; ln < 3; ln++) begin
      for (int c = 0; c < 910; c++) begin
        applyStimulus(c >= 67, c < 130, (c >= 76) && (c < 112), 50, 0, 0);
        tick();
        if (c == 78)
          checkOutput($sformatf("line%0d_burst", ln), int'(DAC_o), (ln % 2 == 0) ? 128 : 352);
        if (ln == 0 && c == 5)
          checkOutput("line_sync", int'(DAC_o), 16);
        if (ln == 0 && c == 300)
          checkOutput("line_active", int'(DAC_o), 382);
      end
    end

    // Reset asserted mid-cycle takes effect without waiting for a clock edge.
    applyStimulus(1'b1, 1'b0, 1'b0, 100, 20, -30);
    repeat (4) tick();
    #2;
    AR_i = 1'b1;
    #1;
    checkOutput("async_rst_dac", int'(DAC_o), 240);
    checkOutput("async_rst_qph", int'(Q_PH_o), 0);
    #1;
    AR_i = 1'b0;
    tick();
    checkOutput("post_rst_dac", int'(DAC_o), 240);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/ntsc_cvbs_enc.md
Name: ntsc_cvbs_enc

Overview:
- Composite-video (CVBS) encoder sitting directly downstream of the NTSC timing generator, in the same 4fsc clock domain.
- Consumes the generator's SYNC/BLANK/BURST strobes plus Y/U/V pixel data from the character-generator path.
- Produces a 10-bit DAC code per 4fsc sample: sync tip, blanking, colour burst and active video with quadrature-modulated chroma.
- Runs at 4fsc, so the subcarrier is a 4-phase sequence and needs no NCO.

Parameters:
- C_SYNC_LEVEL, 10'd16: DAC code for sync tip (-40 IRE).
- C_BLANK_LEVEL, 10'd240: DAC code for blanking (0 IRE).
- C_BLACK_LEVEL, 10'd282: DAC code for black (7.5 IRE setup); luma offset in active video.
- C_BURST_AMP, 10'd112: burst peak deviation from blank (20 IRE).

Ports:
- CK_i  in  1  4fsc clock.
- AR_i  in  1  Reset. Asynchronous, active-high: one clock, async active-high reset.
- XR_i  in  1  Synchronous clear, active-low, qualified by CK_EE_i. Same meaning as the timing generator's XR.
- CK_EE_i  in  1  Clock enable; tie 1 when CK_i is 4fsc. All state advances only when it is 1.
- SYNC_i  in  1  0 = sync, from the timing generator.
- BLANK_i  in  1  1 = blank.
- BURST_i  in  1  1 = burst window.
- Y_i  in  8  Luma, unsigned 0..255.
- U_i  in  8  B-Y, signed two's complement.
- V_i  in  8  R-Y, signed two's complement.
- DAC_o  out  10  Composite code, unsigned, saturated 0..1023.
- Q_SYNC_o  out  1  SYNC_i delayed to align with DAC_o (scope trigger).
- Q_PH_o  out  2  Subcarrier phase of the sample currently on DAC_o.

Behaviour:
- All registers update only on cycles with CK_EE_i=1. With CK_EE_i=0, everything holds.
- Reset (AR_i=1, async):
  - DAC_o = C_BLANK_LEVEL
  - Q_SYNC_o = 1
  - Q_PH_o = 0
  - phase counter = 0
  - every pipeline stage loads blank / SYNC=1 / BLANK=1 / BURST=0 / data 0
- Asserting reset mid-line takes effect immediately. The first post-reset output is blank level.
- Phase counter PH (2 bit):
  - free-running, +1 per enabled cycle, wraps 3→0
  - cleared to 0 on an enabled cycle with XR_i=0
  - 910 samples/line ≡ 2 mod 4, so the subcarrier inverts line-to-line automatically with no extra logic
- Pipeline: three enabled cycles from SYNC_i/BLANK_i/BURST_i/Y/U/V and PH sampled at edge n to DAC_o valid after edge n+3. Strobes and data take the same latency; Q_SYNC_o and Q_PH_o track the same stage.
  - S1: register inputs and PH.
  - S2: compute chroma term C (12-bit signed).
    - Active video: PH 0 → +U, 1 → +V, 2 → -U, 3 → -V. U/V are sign-extended and shifted left 1.
    - Burst: PH 0 → -C_BURST_AMP, 1 → 0, 2 → +C_BURST_AMP, 3 → 0 (burst on the -U axis, 180°).
    - Luma term L = C_BLACK_LEVEL + (Y<<1), max 792.
  - S3: select by priority and saturate.
    - SYNC=0 → C_SYNC_LEVEL. Highest priority; ignores BURST/BLANK.
    - else BURST=1 → C_BLANK_LEVEL + burst C.
    - else BLANK=1 → C_BLANK_LEVEL.
    - else → L + C (active-video chroma).
    - Sum in 12-bit signed; <0 → 0, >1023 → 1023.
- -128 negated = +128 must not overflow; the 12-bit internal width guarantees this.
- Simultaneous BURST=1 with BLANK=1 is the normal case. BURST=1 with BLANK=0 is still encoded as burst.
- XR_i=0 clears only PH; pipeline data keeps flowing.

Test Plan:
1. Reset: hold AR_i=1 with arbitrary inputs → DAC_o=240, Q_SYNC_o=1, Q_PH_o=0. Release AR_i, drive SYNC_i=0 at edge n → DAC_o=16 after edge n+3 and not before.
2. Burst: SYNC=1, BLANK=1, BURST=1 for 8 cycles from PH=0 → DAC_o sequence 128,240,352,240,128,240,352,240.
3. Active chroma: BLANK=0, Y=100, U=+20, V=-30 → DAC_o cycles 522,422,442,542 for PH 0..3.
4. Saturation: Y=255, U=+127 at PH 0 → DAC_o=1023. Y=0, U=+127 at PH 2 → DAC_o=28. Y=0, U=-128 at PH 2 → DAC_o=538. Y=0, V=+127 at PH 3 → DAC_o=28 (no wrap).
5. Line phase: drive a full timing-generator line (910 enabled cycles). First burst sample of consecutive lines shows PH differing by 2, so burst values invert (128 vs 352).
6. Enable/clear: toggle CK_EE_i 1/0 → DAC_o and PH hold on CK_EE_i=0 cycles and latency counts enabled cycles only. XR_i=0 for one enabled cycle → PH=0 next, pipeline contents unchanged.
